onehot_accumulator: RTL and testbench
=====================================

ONEHOT_ACCUMULATOR -- requirements
Module: onehot_accumulator

Interface
REQ-001 Parameter: IDX_W, default 3, index width; vector width VEC_W = 2**IDX_W (8 at default); count width IDX_W+1.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock, all state sampled on it.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  index beat offered.
REQ-006 in_ready  output  1  block accepts index beat.
REQ-007 in_index  input  IDX_W  bit position to set in accumulated vector.
REQ-008 in_last  input  1  beat closes the current packet.
REQ-009 out_valid  output  1  assembled vector available.
REQ-010 out_ready  input  1  downstream consumes vector.
REQ-011 out_vector  output  VEC_W  OR of one-hot decodes of all packet indices.
REQ-012 out_count  output  IDX_W+1  number of distinct indices in packet.
REQ-013 out_dup  output  1  packet contained at least one repeated index.

Function
REQ-014 Two states, COLLECT and HOLD; in_ready = 1 iff state is COLLECT; out_valid = 1 iff state is HOLD; both registered-state decodes, no combinational path from in_valid/out_ready to in_ready/out_valid.
REQ-015 Beat accepted on a rising edge with in_valid=1 and in_ready=1; no other condition.
REQ-016 On accept: acc <= acc | (1 << in_index); if that bit was already set, dup <= 1 and count unchanged, else count <= count + 1.
REQ-017 Accepted beat with in_last=1: accumulation per REQ-016 still applies, state -> HOLD on same edge; out_valid rises the cycle after the last beat (latency 1).
REQ-018 out_vector, out_count, out_dup drive acc, count, dup registers directly at all times; contents defined only while out_valid=1.
REQ-019 In HOLD: acc, count, dup frozen; in_valid, in_index, in_last ignored.
REQ-020 In HOLD with out_ready=1 on an edge: acc, count, dup cleared to 0, state -> COLLECT; in_ready = 1 the following cycle (no same-cycle bypass).
REQ-021 out_ready while in COLLECT has no effect.
REQ-022 Single-beat packet (first beat has in_last=1) is legal; yields exactly one set bit, count 1, dup 0.
REQ-023 count saturates naturally at VEC_W (all bits set); further beats only set dup; no wrap possible since count width is IDX_W+1.
REQ-024 No packet length limit; packet ends only on in_last.
REQ-025 in_index values are always in range by construction (width IDX_W); no error path.

Reset
REQ-026 rst_n low: state = COLLECT, acc = 0, count = 0, dup = 0, immediately and asynchronously; hence in_ready = 1, out_valid = 0, out_vector = 0, out_count = 0, out_dup = 0.
REQ-027 Reset mid-packet or in HOLD discards partial/pending packet; no output is produced for it.
REQ-028 Reset deassertion is synchronised externally; first beat may be accepted on the first rising edge with rst_n high.

Verification
REQ-029 Reset: rst_n low 3 cycles with in_valid toggling -> in_ready=1, out_valid=0, out_vector=0x00, out_count=0, out_dup=0 throughout.
REQ-030 Indices 0,1,2 (last on 2), out_ready=1 -> out_valid high exactly one cycle after beat 2, out_vector=0x07, out_count=3, out_dup=0; in_ready high the following cycle.
REQ-031 Indices 5,5 (last on second 5) -> out_vector=0x20, out_count=1, out_dup=1.
REQ-032 Indices 0..7 then 3 with last -> out_vector=0xFF, out_count=8, out_dup=1; single beat 7 with last -> out_vector=0x80, out_count=1, out_dup=0.
REQ-033 Backpressure: packet 4 last, out_ready low 5 cycles with in_valid=1/in_index=6 driven -> outputs stable at 0x10/1/0, in_ready=0; out_ready high -> next packet (index 1 last) yields 0x02, count 1.
REQ-034 Reset mid-packet: accept 3,4 (no last), pulse rst_n low between edges -> out_vector=0x00 immediately; next packet 1 last -> out_vector=0x02, out_count=1, out_dup=0.

Source files
------------

// File: rtl/onehot_accumulator.sv
// onehot_accumulator
//
// Collects a packet of index beats and ORs the one-hot decode of every index
// into a vector. When the beat flagged in_last is accepted, the packet is
// held on the output side until downstream takes it. Then the block clears
// and returns to collecting.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    index beat offered
//   in_ready    block accepts index beat (high while collecting)
//   in_index    bit position to set, IDX_W bits
//   in_last     beat closes the current packet
//   out_valid   assembled vector available (high while holding)
//   out_ready   downstream consumes the vector
//   out_vector  OR of the one-hot decodes of the packet's indices, 2**IDX_W bits
//   out_count   number of distinct indices in the packet, IDX_W+1 bits
//   out_dup     packet contained at least one repeated index
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_COLLECT | accepting beats and accumulating into acc/count/dup
// ST_HOLD    | packet complete; outputs frozen until out_ready

module onehot_accumulator #(
    parameter int IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_index,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [(2**IDX_W)-1:0] out_vector,
    output logic [IDX_W:0]        out_count,
    output logic                  out_dup
);

    localparam int VEC_W = 2**IDX_W;

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [VEC_W-1:0] acc_q, acc_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             dup_q, dup_d;

    logic [VEC_W-1:0] bit_mask;
    logic             accept;

    always_comb begin
        bit_mask           = '0;
        bit_mask[in_index] = 1'b1;
    end

    assign accept = in_valid && (state_q == ST_COLLECT);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        dup_d   = dup_q;
        if (accept) begin
            acc_d = acc_q | bit_mask;
            // A repeat leaves the distinct count alone. This is also why
            // the count tops out at VEC_W and can never wrap.
            if ((acc_q & bit_mask) != '0) begin
                dup_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
            if (in_last) begin
                state_d = ST_HOLD;
            end
        end else if ((state_q == ST_HOLD) && out_ready) begin
            state_d = ST_COLLECT;
            acc_d   = '0;
            count_d = '0;
            dup_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_COLLECT;
            acc_q   <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            dup_q   <= dup_d;
        end
    end

    // Handshake flags decode the registered state only, so there is no
    // combinational path from in_valid/out_ready to either flag.
    assign in_ready   = (state_q == ST_COLLECT);
    assign out_valid  = (state_q == ST_HOLD);
    assign out_vector = acc_q;
    assign out_count  = count_q;
    assign out_dup    = dup_q;

endmodule

// File: tb/tb_onehot_accumulator.sv
module tb_onehot_accumulator;

    localparam int IDX_W = 3;
    localparam int VEC_W = 2**IDX_W;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_index;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_vector;
    logic [IDX_W:0]   out_count;
    logic             out_dup;

    int n_total;
    int n_pass;
    int n_fail;

    // Reference model: the packet is kept as the list of accepted indices.
    // All expected outputs are derived from that list.
    int pkt[$];
    bit m_hold;

    onehot_accumulator #(.IDX_W(IDX_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_index   (in_index),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vector (out_vector),
        .out_count  (out_count),
        .out_dup    (out_dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VEC_W-1:0] exp_vec();
        logic [VEC_W-1:0] v;
        v = '0;
        foreach (pkt[i]) v[pkt[i]] = 1'b1;
        return v;
    endfunction

    function automatic int exp_cnt();
        return $countones(exp_vec());
    endfunction

    function automatic logic exp_dup();
        return pkt.size() > exp_cnt();
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("in_ready",   32'(in_ready),   32'(!m_hold));
        chk("out_valid",  32'(out_valid),  32'(m_hold));
        chk("out_vector", 32'(out_vector), 32'(exp_vec()));
        chk("out_count",  32'(out_count),  32'(exp_cnt()));
        chk("out_dup",    32'(out_dup),    32'(exp_dup()));
    endtask

    // One clock: update the model from the inputs seen at the edge,
    // then check the DUT 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            pkt.delete();
            m_hold = 1'b0;
        end else if (!m_hold) begin
            if (in_valid) begin
                pkt.push_back(int'(in_index));
                if (in_last) m_hold = 1'b1;
            end
        end else if (out_ready) begin
            pkt.delete();
            m_hold = 1'b0;
        end
        #1;
        check_model();
    endtask

    task automatic drive(input logic v, input int idx, input logic last);
        in_valid = v;
        in_index = IDX_W'(idx);
        in_last  = last;
    endtask

    task automatic beat(input int idx, input logic last);
        drive(1'b1, idx, last);
        tick();
        drive(1'b0, 0, 1'b0);
    endtask

    task automatic expect_out(input string tag, input int vec, input int cnt, input int dup);
        chk({tag, "_valid"}, 32'(out_valid),  32'd1);
        chk({tag, "_vec"},   32'(out_vector), 32'(vec));
        chk({tag, "_cnt"},   32'(out_count),  32'(cnt));
        chk({tag, "_dup"},   32'(out_dup),    32'(dup));
    endtask

    // Reset pulse placed between clock edges.
    task automatic async_reset_pulse();
        rst_n = 1'b0;
        #1;
        pkt.delete();
        m_hold = 1'b0;
        chk("arst_vec",   32'(out_vector), 32'd0);
        chk("arst_cnt",   32'(out_count),  32'd0);
        chk("arst_dup",   32'(out_dup),    32'd0);
        chk("arst_ready", 32'(in_ready),   32'd1);
        chk("arst_valid", 32'(out_valid),  32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        n_fail    = 0;
        m_hold    = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_index  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset held for 3 cycles while in_valid toggles.
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid;
            in_index = IDX_W'($urandom_range(0, VEC_W - 1));
            in_last  = 1'(i);
            tick();
            chk("rst_ready", 32'(in_ready),   32'd1);
            chk("rst_valid", 32'(out_valid),  32'd0);
            chk("rst_vec",   32'(out_vector), 32'd0);
        end
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b0);

        // Indices 0,1,2 with last on 2.
        out_ready = 1'b1;
        beat(0, 1'b0);
        beat(1, 1'b0);
        chk("p1_notyet", 32'(out_valid), 32'd0);
        beat(2, 1'b1);
        expect_out("p1", 'h07, 3, 0);
        tick();
        chk("p1_ready_back", 32'(in_ready), 32'd1);

        // Repeated index.
        beat(5, 1'b0);
        beat(5, 1'b1);
        expect_out("p2", 'h20, 1, 1);
        tick();

        // All indices then a repeat: count saturates at VEC_W.
        for (int i = 0; i < VEC_W; i++) beat(i, 1'b0);
        beat(3, 1'b1);
        expect_out("p3", 'hFF, 8, 1);
        tick();

        // Single-beat packet.
        beat(7, 1'b1);
        expect_out("p4", 'h80, 1, 0);
        tick();

        // Backpressure: HOLD ignores offered beats while out_ready is low.
        beat(4, 1'b1);
        out_ready = 1'b0;
        drive(1'b1, 6, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_last = 1'($urandom_range(0, 1));
            tick();
            expect_out("bp", 'h10, 1, 0);
            chk("bp_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        drive(1'b0, 0, 1'b0);
        beat(1, 1'b1);
        expect_out("p5", 'h02, 1, 0);
        tick();

        // Reset in the middle of a packet.
        beat(3, 1'b0);
        beat(4, 1'b0);
        async_reset_pulse();
        beat(1, 1'b1);
        expect_out("p6", 'h02, 1, 0);
        tick();

        // Random traffic with stalls, gaps, and rare asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_index  = IDX_W'($urandom_range(0, VEC_W - 1));
            in_last   = ($urandom_range(0, 5) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if ($urandom_range(0, 99) == 0) async_reset_pulse();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
